// File: rtl/code_memory_loader.sv
// ---------------------------------------------------------------------------
// code_memory_loader
//   Instruction store for the i281 CPU: DEPTH words of DATA_WIDTH bits.
//   Provides a registered, run-gated instruction fetch, a direct single-word
//   write port, a streaming program loader (valid/ready, wrapping address,
//   word count) and a sequenced clear. The array itself is never reset; it is
//   zeroed word by word in the CLEAR state after reset or on clear_req.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   run, fetch_addr       fetch enable and read address (PC)
//   instr_out             registered instruction word
//   instr_valid           instr_out was refreshed by a fetch last cycle
//   wr_en/wr_addr/wr_data direct write port (IDLE only)
//   load_start            begin streaming load, samples load_base/load_count
//   load_base, load_count first address / word count (0 means DEPTH)
//   load_data/load_valid  stream input
//   load_ready            high for the whole LOAD state
//   load_done             one-cycle pulse after the final load word
//   clear_req             request full-array zeroing (IDLE only)
//   busy                  CLEAR or LOAD in progress
// ---------------------------------------------------------------------------
module code_memory_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_done,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [CNT_WIDTH-1:0]    remaining;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    idle_op_c;
    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_waddr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;
    logic [DATA_WIDTH-1:0]   fetch_data_c;
    logic [ADDR_WIDTH-1:0]   base_mod_c;
    logic [CNT_WIDTH-1:0]    count_eff_c;
    logic [ADDR_WIDTH-1:0]   ptr_next_c;

    // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_CNT);
    endfunction

    // Single memory write port shared by clear, loader and direct write.
    always_comb begin
        idle_op_c   = (state == ST_IDLE) && !clear_req && !load_start;
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        case (state)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_ptr;
            end
            ST_LOAD: begin
                // load_ready is high throughout LOAD, so valid alone is a transfer
                if (load_valid) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = ptr;
                    mem_wdata_c = load_data;
                end
            end
            default: begin
                if (idle_op_c && wr_en && in_range(wr_addr)) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = wr_addr;
                    mem_wdata_c = wr_data;
                end
            end
        endcase
    end

    // Fetch data with write-first bypass; out-of-range reads return zero.
    always_comb begin
        fetch_data_c = '0;
        if (in_range(fetch_addr)) begin
            if (wr_en && (wr_addr == fetch_addr)) begin
                fetch_data_c = wr_data;
            end else begin
                fetch_data_c = mem[fetch_addr];
            end
        end
    end

    // Loader address/count helpers.
    always_comb begin
        base_mod_c  = ADDR_WIDTH'(32'(load_base) % DEPTH);
        count_eff_c = (load_count == '0) ? DEPTH_CNT : load_count;
        ptr_next_c  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
    end

    // Storage array: no reset, cleared by the CLEAR sequence.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            ptr         <= '0;
            remaining   <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            instr_valid <= 1'b0;
            load_done   <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_ptr <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end else if (load_start) begin
                        state      <= ST_LOAD;
                        ptr        <= base_mod_c;
                        remaining  <= count_eff_c;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end else if (run) begin
                        instr_out   <= fetch_data_c;
                        instr_valid <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        ptr       <= ptr_next_c;
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            state      <= ST_IDLE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_code_memory_loader
//   Randomized self-checking bench. A flat array model of the memory plus the
//   expected instr_out register are updated from the behavioural rules; every
//   output is compared through check().
// ---------------------------------------------------------------------------
module tb_code_memory_loader;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clock;
    logic          reset;
    logic          run;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] instr_out;
    logic          instr_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_count;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          load_ready;
    logic          load_done;
    logic          clear_req;
    logic          busy;

    int            total;
    int            bad;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_instr;

    code_memory_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .fetch_addr  (fetch_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_count  (load_count),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .clear_req   (clear_req),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        run        = 1'b0;
        wr_en      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        clear_req  = 1'b0;
    endtask

    // One IDLE cycle: optional fetch and/or direct write.
    task automatic idle_cycle(input logic r, input logic [AW-1:0] fa, input logic we,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic [DW-1:0] e;
        run = r; fetch_addr = fa; wr_en = we; wr_addr = wa; wr_data = wd;
        e = (we && wa == fa) ? wd : model[fa];
        if (r) exp_instr = e;
        if (we) model[wa] = wd;
        step();
        check("idle_ivalid", instr_valid, r);
        check("idle_iout", instr_out, exp_instr);
        check("idle_busy", busy, 0);
        run = 1'b0; wr_en = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            idle_cycle(1'b1, AW'(a), 1'b0, '0, '0);
            check(tag, instr_out, model[a]);
        end
    endtask

    // Count busy cycles of a clear sequence while throwing ignored traffic at it.
    task automatic wait_clear(input string tag);
        int n;
        bit fin;
        n = 0; fin = 0;
        check({tag, "_busy_start"}, busy, 1);
        while (!fin && n < 200) begin
            run        = 1'($urandom);
            fetch_addr = AW'($urandom);
            wr_en      = 1'($urandom);
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
            load_start = 1'($urandom);
            load_base  = AW'($urandom);
            load_count = 7'($urandom);
            clear_req  = 1'($urandom);
            step();
            n++;
            check({tag, "_ivalid"}, instr_valid, 0);
            check({tag, "_iout"}, instr_out, exp_instr);
            check({tag, "_ldone"}, load_done, 0);
            if (!busy) fin = 1;
        end
        quiet_inputs();
        check({tag, "_cycles"}, n, DEPTH);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    // Streaming load. mode 0: valid low every other cycle, data 0xA000+k;
    // mode 1: random valid and data. abort_after >= 0 stops after that many words.
    task automatic do_load(input logic [AW-1:0] base, input logic [AW:0] cnt,
                           input int mode, input int abort_after);
        int n, ptr, acc, cyc;
        bit v, rdy;
        logic [DW-1:0] d;
        n   = (cnt == 0) ? DEPTH : int'(cnt);
        ptr = int'(base) % DEPTH;
        acc = 0; cyc = 0;
        load_start = 1'b1; load_base = base; load_count = cnt;
        run = 1'b1; fetch_addr = AW'($urandom);
        step();
        load_start = 1'b0;
        check("load_enter_busy", busy, 1);
        check("load_enter_ready", load_ready, 1);
        check("load_enter_ivalid", instr_valid, 0);
        check("load_enter_iout", instr_out, exp_instr);
        while (acc < n && cyc < 1000) begin
            if (abort_after >= 0 && acc == abort_after) break;
            v = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom);
            d = (mode == 0) ? DW'(16'hA000 + acc) : DW'($urandom);
            load_valid = v; load_data = d;
            run        = 1'b1;
            fetch_addr = AW'($urandom);
            wr_en      = 1'($urandom);
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
            clear_req  = ($urandom_range(0, 3) == 0);
            rdy = load_ready;
            step();
            cyc++;
            if (v && rdy) begin
                model[ptr] = d;
                ptr = (ptr + 1) % DEPTH;
                acc++;
            end
            check("load_done", load_done, acc == n);
            check("load_ready", load_ready, acc != n);
            check("load_busy", busy, acc != n);
            check("load_ivalid", instr_valid, 0);
            check("load_iout", instr_out, exp_instr);
        end
        quiet_inputs();
        if (abort_after < 0) begin
            check("load_words", acc, n);
            step();
            check("load_done_single", load_done, 0);
            check("load_idle_busy", busy, 0);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        exp_instr = '0;
        quiet_inputs();
        fetch_addr = '0; wr_addr = '0; wr_data = '0;
        load_base = '0; load_count = '0; load_data = '0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_iout", instr_out, 0);
        check("rst_ivalid", instr_valid, 0);
        check("rst_lready", load_ready, 0);
        check("rst_ldone", load_done, 0);
        check("rst_busy", busy, 1);
        reset = 1'b1;
        wait_clear("por");

        idle_cycle(1'b1, 6'h2A, 1'b0, '0, '0);
        check("por_fetch_2a", instr_out, 16'h0000);
        idle_cycle(1'b0, '0, 1'b1, 6'd5, 16'hBEEF);
        idle_cycle(1'b1, 6'd5, 1'b0, '0, '0);
        check("fetch_beef", instr_out, 16'hBEEF);
        idle_cycle(1'b1, 6'd9, 1'b1, 6'd9, 16'h1234);
        check("bypass_1234", instr_out, 16'h1234);

        for (int i = 0; i < 300; i++) begin
            idle_cycle(1'($urandom), AW'($urandom_range(0, 15)), 1'($urandom),
                       AW'($urandom_range(0, 15)), DW'($urandom));
        end

        do_load(6'd62, 7'd4, 0, -1);
        read_all("rd_wrap_load");
        do_load(AW'($urandom), 7'd0, 1, -1);
        read_all("rd_full_load");
        for (int i = 0; i < 3; i++) begin
            do_load(AW'($urandom), 7'($urandom_range(1, 20)), 1, -1);
            for (int j = 0; j < 40; j++) begin
                idle_cycle(1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
            end
        end
        read_all("rd_mixed");

        // Clear request from IDLE; run in the same cycle is ignored.
        clear_req = 1'b1; run = 1'b1; fetch_addr = AW'($urandom);
        step();
        quiet_inputs();
        check("clr_req_ivalid", instr_valid, 0);
        wait_clear("clr");
        read_all("rd_after_clr");

        // Reset in the middle of a load.
        for (int j = 0; j < 20; j++) begin
            idle_cycle(1'b1, AW'($urandom), 1'b1, AW'($urandom), DW'($urandom) | 16'h0001);
        end
        do_load(6'd10, 7'd4, 1, 2);
        reset = 1'b0;
        #1;
        exp_instr = '0;
        check("abort_busy", busy, 1);
        check("abort_lready", load_ready, 0);
        check("abort_ldone", load_done, 0);
        check("abort_iout", instr_out, 0);
        step();
        step();
        reset = 1'b1;
        wait_clear("abort");
        read_all("rd_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
